// File: rtl/intpol2_d4_out_buffer.sv
// rtl/intpol2_d4_out_buffer.sv - FWFT I/Q pair buffer with almost-full back-pressure and frame-last marking
module intpol2_d4_out_buffer #(
  parameter int DATAPATH_WIDTH  = 12,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int AFULL_MARGIN    = 4,
  parameter int LEN_WIDTH       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          wr_en,
  input  logic [DATAPATH_WIDTH-1:0]     I_in,
  input  logic [DATAPATH_WIDTH-1:0]     Q_in,
  input  logic [LEN_WIDTH-1:0]          frame_len,
  output logic                          Afull_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [FIFO_ADDR_WIDTH:0]      level_o,
  output logic                          overflow_o,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [2*DATAPATH_WIDTH-1:0]   m_data,
  output logic                          m_last
);

  localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
  localparam int LW    = FIFO_ADDR_WIDTH + 1;
  localparam int DW    = 2 * DATAPATH_WIDTH;

  logic [DW-1:0]              mem_q [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]              level_q, level_d;
  logic                       overflow_q, overflow_d;
  logic [LEN_WIDTH-1:0]       cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]       len_q, len_d;
  logic [LEN_WIDTH-1:0]       eff_len;
  logic                       flush;
  logic                       push;
  logic                       pop;

  assign flush = rst || clear;

  assign level_o    = level_q;
  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == LW'(DEPTH));
  assign Afull_o    = (level_q >= LW'(DEPTH - AFULL_MARGIN));
  assign overflow_o = overflow_q;

  assign m_valid = !empty_o;
  assign m_data  = m_valid ? mem_q[rd_ptr_q] : '0;

  // The length register is transparent to frame_len while the counter sits at
  // frame start, so a one-beat frame can flag last on its first beat.
  assign eff_len = (cnt_q == '0) ? frame_len : len_q;
  assign m_last  = m_valid && (eff_len != '0) && (cnt_q == eff_len - LEN_WIDTH'(1));

  // A pop in the same cycle does not make room for a write while full.
  assign push = wr_en && !full_o;
  assign pop  = m_valid && m_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    cnt_d      = cnt_q;
    len_d      = eff_len;
    if (push) begin
      wr_ptr_d = wr_ptr_q + FIFO_ADDR_WIDTH'(1);
    end
    if (wr_en && full_o) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
      cnt_d    = m_last ? '0 : cnt_q + LEN_WIDTH'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
      len_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= {Q_in, I_in};
    end
  end

endmodule

// File: tb/tb_intpol2_d4_out_buffer.sv
// tb/tb_intpol2_d4_out_buffer.sv - randomized self-checking bench against a queue-based reference model
module tb_intpol2_d4_out_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        wr_en = 1'b0;
  logic [11:0] I_in = '0;
  logic [11:0] Q_in = '0;
  logic [31:0] frame_len = '0;
  logic        Afull_o, full_o, empty_o, overflow_o;
  logic [4:0]  level_o;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [23:0] m_data;
  logic        m_last;

  intpol2_d4_out_buffer dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en),
    .I_in(I_in), .Q_in(Q_in), .frame_len(frame_len),
    .Afull_o(Afull_o), .full_o(full_o), .empty_o(empty_o), .level_o(level_o),
    .overflow_o(overflow_o), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [23:0] mq[$];
  bit          m_ovf = 1'b0;
  logic [31:0] beat = '0;
  logic [31:0] saved_len = '0;

  int          pop_idx = 0;
  int          last_pops[$];
  bit          prev_stall = 1'b0;
  logic [23:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cur_len();
    return (beat == 0) ? frame_len : saved_len;
  endfunction

  function automatic bit exp_last();
    return (mq.size() > 0) && (cur_len() != 0) && (beat + 1 == cur_len());
  endfunction

  task automatic check_outputs();
    int n;
    n = mq.size();
    chk("level", 32'(level_o), 32'(n));
    chk("empty", 32'(empty_o), 32'(n == 0));
    chk("full", 32'(full_o), 32'(n == 16));
    chk("afull", 32'(Afull_o), 32'(n >= 12));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("m_valid", 32'(m_valid), 32'(n > 0));
    chk("m_data", 32'(m_data), (n > 0) ? 32'(mq[0]) : 32'd0);
    chk("m_last", 32'(m_last), 32'(exp_last()));
  endtask

  // One clock: drive inputs, compare outputs against the model, advance model on the edge.
  task automatic step(input bit wr, input logic [11:0] i, input logic [11:0] q, input bit rdy);
    bit obs_pop, obs_last, lst, pop, was_full;
    wr_en = wr; I_in = i; Q_in = q; m_ready = rdy;
    #1;
    check_outputs();
    if (prev_stall) begin
      chk("hold_data", 32'(m_data), 32'(prev_data));
      chk("hold_last", 32'(m_last), 32'(prev_last));
    end
    obs_pop  = m_valid && m_ready && !rst && !clear;
    obs_last = m_last;
    prev_stall = m_valid && !m_ready && !rst && !clear;
    prev_data  = m_data;
    prev_last  = m_last;
    @(posedge clk);
    if (rst || clear) begin
      mq.delete();
      m_ovf = 1'b0;
      beat = 0;
      saved_len = 0;
    end else begin
      lst = exp_last();
      pop = (mq.size() > 0) && rdy;
      was_full = (mq.size() == 16);
      if (beat == 0) saved_len = frame_len;
      if (wr && was_full) m_ovf = 1'b1;
      if (pop) begin
        void'(mq.pop_front());
        beat = lst ? 32'd0 : beat + 1;
      end
      if (wr && !was_full) mq.push_back({q, i});
    end
    if (obs_pop) begin
      pop_idx++;
      if (obs_last) last_pops.push_back(pop_idx);
    end
    #1;
  endtask

  initial begin
    logic [11:0] ri, rq;
    @(posedge clk); #1;

    // Reset held two cycles with writes attempted
    rst = 1'b1;
    step(1'b1, 12'h5a5, 12'h3c3, 1'b0);
    step(1'b1, 12'h5a5, 12'h3c3, 1'b0);
    rst = 1'b0;
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_data", 32'(m_data), 32'd0);

    // Fill with I=k, Q=-k and watch the flag boundaries
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 12'(k), 12'(-k), 1'b0);
      if (k == 11) chk("afull_at_11", 32'(Afull_o), 32'd0);
      if (k == 12) chk("afull_at_12", 32'(Afull_o), 32'd1);
      if (k == 15) chk("full_at_15", 32'(full_o), 32'd0);
    end
    chk("full_at_16", 32'(full_o), 32'd1);
    step(1'b1, 12'd17, 12'(-17), 1'b0);
    chk("ovf_17th", 32'(overflow_o), 32'd1);
    chk("level_17th", 32'(level_o), 32'd16);
    chk("head_first", 32'(m_data), {8'd0, 12'hfff, 12'h001});

    // Drain with interleaved random writes across pointer wrap
    for (int b = 0; b < 40; b++) begin
      ri = 12'($urandom); rq = 12'($urandom);
      step(1'($urandom_range(0, 1)), ri, rq, 1'b1);
    end

    // Flush, then simultaneous write+pop at level 5
    clear = 1'b1;
    step(1'b1, 12'h111, 12'h222, 1'b1);
    clear = 1'b0;
    chk("clear_level", 32'(level_o), 32'd0);
    chk("clear_ovf", 32'(overflow_o), 32'd0);
    for (int k = 0; k < 5; k++) step(1'b1, 12'(k + 100), 12'(k + 200), 1'b0);
    step(1'b1, 12'h0aa, 12'h0bb, 1'b1);
    chk("wr_pop_at_5", 32'(level_o), 32'd5);
    for (int k = 0; k < 20 && mq.size() > 0; k++) step(1'b0, 12'h0, 12'h0, 1'b1);
    chk("drained", 32'(level_o), 32'd0);
    step(1'b1, 12'h123, 12'h456, 1'b1);
    chk("wr_at_0_level", 32'(level_o), 32'd1);
    chk("wr_at_0_data", 32'(m_data), {8'd0, 12'h456, 12'h123});

    // Random back-pressure with hold checks
    frame_len = 32'd4;
    for (int b = 0; b < 40; b++) begin
      ri = 12'($urandom); rq = 12'($urandom);
      step(1'($urandom_range(0, 3) != 0), ri, rq, 1'($urandom_range(0, 1)));
    end
    prev_stall = 1'b0;

    // Framing: len 3, 7 beats, length change during beat 5
    clear = 1'b1;
    frame_len = 32'd3;
    step(1'b0, 12'h0, 12'h0, 1'b0);
    clear = 1'b0;
    for (int k = 1; k <= 7; k++) step(1'b1, 12'(k), 12'(k + 50), 1'b0);
    pop_idx = 0;
    last_pops.delete();
    for (int k = 1; k <= 7; k++) begin
      if (k == 5) frame_len = 32'd2;
      step(1'b0, 12'h0, 12'h0, 1'b1);
    end
    chk("last_count", 32'(last_pops.size()), 32'd2);
    if (last_pops.size() == 2) begin
      chk("last_beat_a", 32'(last_pops[0]), 32'd3);
      chk("last_beat_b", 32'(last_pops[1]), 32'd6);
    end

    // Clear mid-frame, next frame counts from beat 1
    frame_len = 32'd3;
    for (int k = 0; k < 4; k++) step(1'b1, 12'(k + 70), 12'(k + 80), 1'b0);
    step(1'b0, 12'h0, 12'h0, 1'b1);
    clear = 1'b1;
    step(1'b1, 12'h0, 12'h0, 1'b1);
    clear = 1'b0;
    chk("midclr_empty", 32'(empty_o), 32'd1);
    for (int k = 0; k < 4; k++) step(1'b1, 12'(k + 90), 12'(k + 95), 1'b0);
    pop_idx = 0;
    last_pops.delete();
    for (int k = 0; k < 4; k++) step(1'b0, 12'h0, 12'h0, 1'b1);
    chk("post_clear_last_n", 32'(last_pops.size()), 32'd1);
    if (last_pops.size() == 1) chk("post_clear_last", 32'(last_pops[0]), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/intpol2_d4_out_buffer.md
Name: intpol2_D4_out_buffer

Overview:
Downstream stage of the IQ quadratic interpolator core. It buffers interpolated I/Q sample pairs written through the core's FIFO write strobe. It drives the almost-full back-pressure flag that the core uses to stall. It drains the pairs to a valid/ready stream consumer and marks the frame end with last after a programmed number of beats.

Parameters:
DATAPATH_WIDTH, 12, width of each I and Q sample (two's complement)
FIFO_ADDR_WIDTH, 4, log2 of buffer depth; DEPTH = 2**FIFO_ADDR_WIDTH (16)
AFULL_MARGIN, 4, Afull_o asserts when occupancy >= DEPTH-AFULL_MARGIN; must be >= 1 and < DEPTH
LEN_WIDTH, 32, width of the frame-length input

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
clear  in  1  synchronous flush, active-high; same effect as rst, lower priority
wr_en  in  1  write strobe from core (Write_Enable_fifo)
I_in  in  DATAPATH_WIDTH  interpolated I sample
Q_in  in  DATAPATH_WIDTH  interpolated Q sample
frame_len  in  LEN_WIDTH  beats per frame; 0 = last never asserted; sampled when beat counter is 0
Afull_o  out  1  almost-full to core (Afull_i)
full_o  out  1  occupancy == DEPTH
empty_o  out  1  occupancy == 0
level_o  out  FIFO_ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow_o  out  1  sticky: a write was dropped
m_valid  out  1  head entry available
m_ready  in  1  consumer accepts
m_data  out  2*DATAPATH_WIDTH  {Q,I}; Q in upper half
m_last  out  1  qualifies m_data as final beat of frame

Behaviour:
- Reset/clear values: all pointers 0, level_o=0, empty_o=1, full_o=0, Afull_o=0, overflow_o=0, m_valid=0, m_last=0, m_data=0, beat counter 0. rst or clear in the middle of a frame discards all stored data and the partial beat count in that cycle. Writes and reads in that cycle are ignored.
- Write accepted on posedge when wr_en=1 and occupancy before the edge < DEPTH. A write while full is dropped and sets overflow_o=1 (sticky until rst/clear). A read in the same cycle does NOT rescue a write while full.
- Read (pop) occurs on posedge when m_valid=1 and m_ready=1.
- Occupancy update per edge: +1 on write only, -1 on pop only, unchanged on write+pop.
- Flags empty_o, full_o, Afull_o and level_o are combinational from the registered occupancy, i.e. they update the cycle after the causing edge. Afull_o = (level >= DEPTH-AFULL_MARGIN).
- The margin absorbs the core's in-flight writes after Afull_o rises. With defaults, Afull_o rises at level 12, leaving 4 slots.
- Read path is first-word-fall-through: m_valid = !empty. m_data presents the head entry.
- Latency: a write into an empty buffer at edge N gives m_valid=1 and valid m_data after edge N.
- m_data and m_last are held stable while m_valid=1 and m_ready=0.
- Pointers are FIFO_ADDR_WIDTH bits and wrap modulo DEPTH. Full and empty are distinguished by occupancy, not pointer equality.
- Sample data is stored unmodified; no saturation or sign handling. Q and I stay aligned as one entry.
- Frame counter (LEN_WIDTH bits) counts pops. When the counter is 0, the length register is loaded from frame_len.
- m_last = m_valid && len != 0 && counter == len-1.
- On a pop with m_last=1 the counter returns to 0; otherwise it increments.
- With len == 0 the counter still counts, wraps naturally, and never asserts m_last.
- frame_len changes mid-frame take effect only at the next frame start.
- m_ready while m_valid=0 has no effect.

Test Plan:
- Reset check: drive rst=1 for 2 cycles with wr_en=1 -> all outputs at reset values, level_o=0, no entry stored.
- Fill/flags: m_ready=0, write 16 pairs I=k, Q=-k (k=1..16) -> Afull_o rises the cycle after the 12th write. full_o=1 after the 16th write. A 17th write sets overflow_o=1 and level_o stays 16.
- Drain order/wrap: continue with m_ready=1 and interleaved writes for 40 beats -> m_data sequence equals write order {Q,I} exactly across pointer wrap, and level_o is consistent every cycle.
- Simultaneous write+pop at level 5 -> level_o stays 5. At level 0, a write with m_ready=1 -> no pop that cycle, level_o=1 next cycle.
- Back-pressure hold: m_valid=1 with m_ready toggling 0/1 randomly -> m_data and m_last are unchanged on every cycle with m_ready=0.
- Framing: frame_len=3, stream 7 beats -> m_last on beats 3 and 6. Change frame_len to 2 during beat 5 -> the next frame is still 3 beats. clear asserted mid-frame -> buffer empty, the next frame counts from beat 1.
